// File: rtl/sram_stream_reader.sv
// Streams bursts of SRAM words out as single elements, lane 0 first.
// One FETCH and one LATCH cycle per word, then one DRAIN cycle per element; Out_Ready low holds the element.
module sram_stream_reader #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int para_deg   = 4
) (
    input  logic                           clk,
    input  logic                           Rst_n,
    input  logic                           Start,
    input  logic [addr_width-1:0]          Start_Addr,
    input  logic [addr_width:0]            Word_Count,
    output logic                           Busy,
    output logic                           Done,
    output logic                           Chip_Select,
    output logic                           En_Read,
    output logic [addr_width-1:0]          Read_Addr,
    input  logic [para_deg*data_width-1:0] Read_Data,
    output logic                           Out_Valid,
    input  logic                           Out_Ready,
    output logic [data_width-1:0]          Out_Data,
    output logic                           Out_Last
);

    localparam int LW = (para_deg > 1) ? $clog2(para_deg) : 1;
    localparam logic [LW-1:0]         LAST_LANE = LW'(para_deg - 1);
    localparam logic [LW-1:0]         LANE_ONE  = LW'(1);
    localparam logic [addr_width:0]   CNT_ONE   = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] ADDR_ONE  = addr_width'(1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DRAIN, FINISH} state_t;

    state_t                         state_q, state_d;
    logic [addr_width-1:0]          addr_q, addr_d;
    logic [addr_width:0]            cnt_q, cnt_d;
    logic [LW-1:0]                  lane_q, lane_d;
    logic [para_deg*data_width-1:0] buf_q, buf_d;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Word_Count != '0) begin
                        addr_d  = Start_Addr;
                        cnt_d   = Word_Count;
                        state_d = FETCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FETCH: state_d = LATCH;
            // SRAM data is valid one cycle after the FETCH edge
            LATCH: begin
                buf_d   = Read_Data;
                lane_d  = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (Out_Ready) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d  = '0;
                        cnt_d   = cnt_q - CNT_ONE;
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = (cnt_q == CNT_ONE) ? FINISH : FETCH;
                    end else begin
                        lane_d = lane_q + LANE_ONE;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Busy        = (state_q != IDLE);
    assign Done        = (state_q == FINISH);
    assign Chip_Select = (state_q == FETCH);
    assign En_Read     = (state_q == FETCH);
    assign Read_Addr   = addr_q;
    assign Out_Valid   = (state_q == DRAIN);
    assign Out_Data    = buf_q[lane_q*data_width +: data_width];
    assign Out_Last    = (state_q == DRAIN) && (lane_q == LAST_LANE) && (cnt_q == CNT_ONE);

endmodule
